// File: rtl/shift_arbiter.sv
// Two-port round-robin front end for a shared register-controlled barrel shifter.
// Each result is held in a single output register, along with its source port and tag, under valid/ready backpressure.
module shift_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [31:0]      req_rs0,
  input  logic [31:0]      req_rs1,
  input  logic [1:0]       req_ctl0,
  input  logic [1:0]       req_ctl1,
  input  logic [31:0]      req_rm0,
  input  logic [31:0]      req_rm1,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [TAG_W-1:0] req_tag1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_src,
  output logic [TAG_W-1:0] res_tag
);

  typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11} shift_e;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  function automatic logic [31:0] barrel(input logic [31:0] rm, input logic [7:0] n,
                                         input shift_e op);
    logic [31:0] r;
    logic [4:0]  rot;
    rot = n[4:0];
    r   = rm;
    unique case (op)
      SH_LSL: if (n >= 8'd32) r = '0; else r = rm << n[4:0];
      SH_LSR: if (n >= 8'd32) r = '0; else r = rm >> n[4:0];
      SH_ASR: if (n >= 8'd32) r = {32{rm[31]}}; else r = $unsigned($signed(rm) >>> n[4:0]);
      // n == 0 also has rot == 0, so a single test covers both pass-through cases.
      SH_ROR: if (rot != 5'd0) r = (rm >> rot) | (rm << (6'd32 - {1'b0, rot}));
      default: r = rm;
    endcase
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [31:0]      data_q, data_d;
  logic             src_q, src_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             last_q, last_d;

  logic       free;
  logic [1:0] grant;
  logic       accept;
  logic       sel;
  logic [31:0] sh_out;
  logic       unused_rs_hi;

  // Only the low byte of each shift-amount register participates in the shift.
  assign unused_rs_hi = ^{req_rs0[31:8], req_rs1[31:8]};

  assign free     = (state_q == EMPTY) || res_ready;
  assign grant[0] = req_valid[0] & (~req_valid[1] | last_q);
  assign grant[1] = req_valid[1] & (~req_valid[0] | ~last_q);
  // rst_n gates the handshake so that no request is acknowledged while the block is held in reset.
  assign req_ready = grant & {2{free & rst_n}};
  assign accept    = |(req_valid & req_ready);
  assign sel       = req_ready[1];

  assign sh_out = sel ? barrel(req_rm1, req_rs1[7:0], shift_e'(req_ctl1))
                      : barrel(req_rm0, req_rs0[7:0], shift_e'(req_ctl0));

  // NOTE: every always_comb output is given a default first, so that no path leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    tag_d   = tag_q;
    last_d  = last_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (!accept && res_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (accept) begin
      data_d = sh_out;
      src_d  = sel;
      tag_d  = sel ? req_tag1 : req_tag0;
      last_d = sel;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples the value from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      src_q   <= 1'b0;
      tag_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      tag_q   <= tag_d;
      last_q  <= last_d;
    end
  end

  assign res_valid = (state_q == FULL);
  assign res_data  = data_q;
  assign res_src   = src_q;
  assign res_tag   = tag_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter. The stimulus pushes hand-computed results into a queue.
// A separate monitor pops an entry and compares it each time the DUT drains a result.
module tb_shift_arbiter;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [31:0]      data;
    logic             src;
    logic [TAG_W-1:0] tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [31:0]      req_rs0 = '0, req_rs1 = '0;
  logic [1:0]       req_ctl0 = '0, req_ctl1 = '0;
  logic [31:0]      req_rm0 = '0, req_rm1 = '0;
  logic [TAG_W-1:0] req_tag0 = '0, req_tag1 = '0;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [31:0]      res_data;
  logic             res_src;
  logic [TAG_W-1:0] res_tag;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  shift_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_rs0(req_rs0), .req_rs1(req_rs1), .req_ctl0(req_ctl0), .req_ctl1(req_ctl1),
    .req_rm0(req_rm0), .req_rm1(req_rm1), .req_tag0(req_tag0), .req_tag1(req_tag1),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_src(res_src), .res_tag(res_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_p0(input logic [31:0] rm, input logic [1:0] ctl, input logic [31:0] rs,
                        input logic [3:0] tag);
    req_rm0 = rm; req_ctl0 = ctl; req_rs0 = rs; req_tag0 = tag;
  endtask

  task automatic set_p1(input logic [31:0] rm, input logic [1:0] ctl, input logic [31:0] rs,
                        input logic [3:0] tag);
    req_rm1 = rm; req_ctl1 = ctl; req_rs1 = rs; req_tag1 = tag;
  endtask

  // One clock: check req_ready mid-cycle, queue the expected result of the accept, then move past the edge.
  task automatic cycle(input logic [1:0] exp_rdy, input logic [31:0] exp_data);
    exp_t e;
    @(negedge clk);
    check("req_ready", {30'd0, req_ready}, {30'd0, exp_rdy});
    if (exp_rdy != 2'b00) begin
      e.data = exp_data;
      e.src  = exp_rdy[1];
      e.tag  = exp_rdy[1] ? req_tag1 : req_tag0;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each result on the cycle in which it is drained.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", {31'd0, res_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_data", res_data, e.data);
        check("res_src", {31'd0, res_src}, {31'd0, e.src});
        check("res_tag", {28'd0, res_tag}, {28'd0, e.tag});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, with both ports requesting while reset is held.
    req_valid = 2'b11;
    #12;
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_src", {31'd0, res_src}, 32'd0);
    check("rst_res_tag", {28'd0, res_tag}, 32'd0);
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    req_valid = 2'b00;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First accept is visible on the cycle after the edge.
    set_p0(32'h0000_00F0, 2'b00, 32'd4, 4'h3);
    req_valid = 2'b01;
    cycle(2'b01, 32'h0000_0F00);
    req_valid = 2'b00;
    check("lat_res_valid", {31'd0, res_valid}, 32'd1);
    cycle(2'b00, 32'd0);
    check("drain_res_valid", {31'd0, res_valid}, 32'd0);

    // Boundary shifts from port 1 alone, issued back-to-back.
    req_valid = 2'b10;
    set_p1(32'h8000_0001, 2'b10, 32'h20, 4'h1);  cycle(2'b10, 32'hFFFF_FFFF);
    set_p1(32'h8000_0001, 2'b01, 32'h100, 4'h2); cycle(2'b10, 32'h8000_0001);
    set_p1(32'h8000_0001, 2'b11, 32'h1, 4'h3);   cycle(2'b10, 32'hC000_0000);
    set_p1(32'h8000_0001, 2'b11, 32'h20, 4'h4);  cycle(2'b10, 32'h8000_0001);
    set_p1(32'h8000_0001, 2'b00, 32'd32, 4'h5);  cycle(2'b10, 32'h0000_0000);
    req_valid = 2'b00;
    cycle(2'b00, 32'd0);

    // Contention with last = 1: expected order is 0, 1, 0, 1 with no idle cycle.
    set_p0(32'h0000_0001, 2'b00, 32'd1, 4'h8);
    set_p1(32'h1234_5678, 2'b11, 32'd8, 4'hA);
    req_valid = 2'b11;
    cycle(2'b01, 32'h0000_0002);
    set_p0(32'hF000_0000, 2'b10, 32'd4, 4'h9);
    cycle(2'b10, 32'h7812_3456);
    set_p1(32'hFFFF_FFFF, 2'b01, 32'd31, 4'hB);
    cycle(2'b01, 32'hFF00_0000);
    set_p0(32'hA5A5_A5A5, 2'b01, 32'd0, 4'hC);
    cycle(2'b10, 32'h0000_0001);
    set_p1(32'h0000_FFFF, 2'b00, 32'd16, 4'hD);

    // Stall for 3 cycles: no grants, and the held result stays stable.
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(2'b00, 32'd0);
      check("stall_valid", {31'd0, res_valid}, 32'd1);
      check("stall_data", res_data, 32'h0000_0001);
      check("stall_src", {31'd0, res_src}, 32'd1);
      check("stall_tag", {28'd0, res_tag}, 32'hB);
    end
    // Releasing the stall drains and accepts in the same cycle; priority did not rotate.
    res_ready = 1'b1;
    cycle(2'b01, 32'hA5A5_A5A5);
    check("refill_valid", {31'd0, res_valid}, 32'd1);
    req_valid = 2'b10;
    cycle(2'b10, 32'hFFFF_0000);
    req_valid = 2'b00;
    cycle(2'b00, 32'd0);

    // Asynchronous reset between edges while a result is held.
    res_ready = 1'b0;
    set_p0(32'h0000_0003, 2'b00, 32'd1, 4'hE);
    req_valid = 2'b01;
    cycle(2'b01, 32'h0000_0006);
    check("pre_rst_valid", {31'd0, res_valid}, 32'd1);
    req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, res_valid}, 32'd0);
    check("async_rst_ready", {30'd0, req_ready}, 32'd0);
    check("async_rst_data", res_data, 32'd0);
    sb.delete();
    rst_n = 1'b1;
    res_ready = 1'b1;
    set_p0(32'h8000_0000, 2'b11, 32'd31, 4'h1);
    set_p1(32'h0000_0005, 2'b00, 32'd0, 4'h2);
    cycle(2'b01, 32'h0000_0001);
    cycle(2'b10, 32'h0000_0005);
    req_valid = 2'b00;
    cycle(2'b00, 32'd0);
    cycle(2'b00, 32'd0);

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
